// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU over a fixed number of cycles, plus MTHI/MTLO.
// Result is computed from operands latched at accept and committed when the cycle counter expires.
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          done_q, done_d;

    logic [63:0]   prod;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

    // op_q[1] selects divide, op_q[0] selects unsigned
    always_comb begin
        if (op_q[0]) begin
            prod = {32'b0, a_q} * {32'b0, b_q};
        end else begin
            prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        end
        a_neg   = ~op_q[0] & a_q[31];
        b_neg   = ~op_q[0] & b_q[31];
        a_mag   = a_neg ? (32'd0 - a_q) : a_q;
        b_mag   = b_neg ? (32'd0 - b_q) : b_q;
        // B==0 never commits; a dummy divisor keeps the datapath free of x
        divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        // 0x80000000 / -1 wraps back to 0x80000000 with zero remainder
        quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            op_d    = md_op[1:0];
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CW'(MUL_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = md_op[1:0];
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus randomized op streams against an arithmetic model.
module tb_mult_div_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          pass_cnt = 0;
    int          total    = 0;
    logic [31:0] exp_hi, exp_lo;

    mult_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
        .A(A), .B(B), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Architectural effect of one op on HI/LO
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              q, r;
        case (op)
            3'd0: begin sp = longint'(int'(a)) * longint'(int'(b)); {exp_hi, exp_lo} = sp; end
            3'd1: begin up = {32'b0, a} * {32'b0, b}; {exp_hi, exp_lo} = up; end
            3'd2: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    exp_lo = a; exp_hi = 0;
                end else begin
                    q = int'(a) / int'(b); r = int'(a) % int'(b);
                    exp_lo = q; exp_hi = r;
                end
            end
            3'd3: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op);
        if (op <= 3'd1) return MUL_N;
        if (op <= 3'd3) return DIV_N;
        return 0;
    endfunction

    // Issue one op from a point #1 after a posedge; returns in the first cycle busy is low
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        start = 1'b1; md_op = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'b110; A = $urandom; B = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        model(op, a, b);
    endtask

    task automatic test_reset;
        int cyc;
        rst_n = 1'b0; start = 1'b0; md_op = 3'b110; A = 0; B = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else pass_cnt++;
        total++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else pass_cnt++;
        rst_n = 1'b1;
        exp_hi = 0; exp_lo = 0;
        run_op(3'd4, 32'hDEAD_0001, 32'd0, cyc);
        run_op(3'd5, 32'hDEAD_0002, 32'd0, cyc);
        // Reset mid-run: outputs clear without a clock edge
        start = 1'b1; md_op = 3'd0; A = 32'd7; B = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'b110;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL midrun_reset_busy got %b want 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL midrun_reset_done got %b want 0", done); else pass_cnt++;
        total++; if (hi !== 32'd0) $display("FAIL midrun_reset_hi got %h want 0", hi); else pass_cnt++;
        total++; if (lo !== 32'd0) $display("FAIL midrun_reset_lo got %h want 0", lo); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_hi = 0; exp_lo = 0;
        run_op(3'd1, 32'd1000, 32'd2000, cyc);
        total++; if (cyc != MUL_N) $display("FAIL post_reset_busy got %0d want %0d", cyc, MUL_N); else pass_cnt++;
        total++; if (lo !== exp_lo || hi !== exp_hi)
            $display("FAIL post_reset_result got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); else pass_cnt++;
    endtask

    task automatic test_mult;
        int cyc;
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, cyc);
        total++; if (cyc != MUL_N) $display("FAIL mult_busy got %0d want %0d", cyc, MUL_N); else pass_cnt++;
        total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", hi); else pass_cnt++;
        total++; if (lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo got %h want fffffffa", lo); else pass_cnt++;
        total++; if (done !== 1'b1) $display("FAIL mult_done got %b want 1", done); else pass_cnt++;
        @(posedge clk); #1;
        total++; if (done !== 1'b0) $display("FAIL mult_done_width got %b want 0", done); else pass_cnt++;
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001)
            $display("FAIL multu_max got %h_%h want fffffffe_00000001", hi, lo); else pass_cnt++;
    endtask

    task automatic test_div;
        int cyc;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
        total++; if (cyc != DIV_N) $display("FAIL div_busy got %0d want %0d", cyc, DIV_N); else pass_cnt++;
        total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h want fffffffd", lo); else pass_cnt++;
        total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h want ffffffff", hi); else pass_cnt++;
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        total++; if (lo !== 32'h8000_0000 || hi !== 32'd0)
            $display("FAIL div_overflow got %h_%h want 00000000_80000000", hi, lo); else pass_cnt++;
    endtask

    task automatic test_div_zero;
        int cyc;
        run_op(3'd4, 32'h1111, 32'd0, cyc);
        run_op(3'd5, 32'h2222, 32'd0, cyc);
        run_op(3'd3, 32'h1234_5678, 32'd0, cyc);
        total++; if (cyc != DIV_N) $display("FAIL divz_busy got %0d want %0d", cyc, DIV_N); else pass_cnt++;
        total++; if (done !== 1'b1) $display("FAIL divz_done got %b want 1", done); else pass_cnt++;
        total++; if (hi !== 32'h1111 || lo !== 32'h2222)
            $display("FAIL divz_hold got %h_%h want 00001111_00002222", hi, lo); else pass_cnt++;
        run_op(3'd2, 32'hFFFF_0000, 32'd0, cyc);
        total++; if (hi !== 32'h1111 || lo !== 32'h2222)
            $display("FAIL divz_signed_hold got %h_%h want 00001111_00002222", hi, lo); else pass_cnt++;
    endtask

    task automatic test_ignore_in_run;
        int cyc;
        start = 1'b1; md_op = 3'd0; A = 32'd2; B = 32'd3;
        @(posedge clk); #1;
        // Hold an MTLO request and scramble operands for the whole run
        md_op = 3'd5; A = 32'h55; B = 32'hFFFF_FFFF;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++; if (cyc != MUL_N) $display("FAIL ign_busy got %0d want %0d", cyc, MUL_N); else pass_cnt++;
        total++; if (lo !== 32'd6 || hi !== 32'd0) $display("FAIL ign_result got %h_%h want 0_6", hi, lo); else pass_cnt++;
        total++; if (done !== 1'b1) $display("FAIL ign_done got %b want 1", done); else pass_cnt++;
        md_op = 3'd4; A = 32'hAB;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'b110;
        total++; if (hi !== 32'hAB) $display("FAIL mthi_on_done got %h want ab", hi); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL mthi_busy got %b want 0", busy); else pass_cnt++;
        total++; if (lo !== 32'd6) $display("FAIL mthi_lo_kept got %h want 6", lo); else pass_cnt++;
        exp_hi = 32'hAB; exp_lo = 32'd6;
    endtask

    // Random ops issued back to back: each new op starts in the done cycle of the previous one
    task automatic test_back_to_back;
        int          cyc;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: ;
            endcase
            run_op(op, a, b, cyc);
            total++; if (cyc != latency(op)) $display("FAIL rnd%0d_busy op=%0d got %0d want %0d", i, op, cyc, latency(op)); else pass_cnt++;
            total++; if (done !== (op <= 3'd3)) $display("FAIL rnd%0d_done op=%0d got %b want %b", i, op, done, op <= 3'd3); else pass_cnt++;
            total++; if (hi !== exp_hi) $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, op, a, b, hi, exp_hi); else pass_cnt++;
            total++; if (lo !== exp_lo) $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, op, a, b, lo, exp_lo); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_ignore_in_run;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
